// File: rtl/fetch_stage_ctrl_if.sv
// Fetch-stage bus: hazard/branch controls and instruction-memory data in,
// fetch address and IF/ID pipeline register contents out.
interface fetch_stage_ctrl_if;
  logic        pcwrite_i;
  logic        ifid_write_i;
  logic        ifid_flush_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic [31:0] instr_i;
  logic [31:0] pc_o;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc4_o;
  logic        ifid_valid_o;

  modport master (
    output pcwrite_i, ifid_write_i, ifid_flush_i, branch_taken_i,
           branch_target_i, instr_i,
    input  pc_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o
  );

  modport slave (
    input  pcwrite_i, ifid_write_i, ifid_flush_i, branch_taken_i,
           branch_target_i, instr_i,
    output pc_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o
  );
endinterface

// File: rtl/fetch_stage_ctrl.sv
// Instruction-fetch front end: PC and IF/ID register under hazard-unit control,
// with a RUN/STALL/REDIRECT tracker, saturating event counters and a stall watchdog.
module fetch_stage_ctrl #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter int          CNT_W     = 16,
  parameter int          MAX_STALL = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  fetch_stage_ctrl_if.slave   bus,
  output logic [1:0]          state_o,
  output logic [CNT_W-1:0]    stall_cnt_o,
  output logic [CNT_W-1:0]    flush_cnt_o,
  output logic                stall_err_o
);

  localparam int RUN_W = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] MAX_RUN = RUN_W'(MAX_STALL);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t            state_r,     state_nxt_s;
  logic [31:0]       pc_r,        pc_nxt_s;
  logic [31:0]       instr_r,     instr_nxt_s;
  logic [31:0]       pc4_r,       pc4_nxt_s;
  logic              valid_r,     valid_nxt_s;
  logic [CNT_W-1:0]  stall_cnt_r, stall_cnt_nxt_s;
  logic [CNT_W-1:0]  flush_cnt_r, flush_cnt_nxt_s;
  logic [RUN_W-1:0]  run_r,       run_nxt_s;
  logic              err_r,       err_nxt_s;
  logic              stall_s;
  logic              flush_s;
  logic [31:0]       pc_plus4_s;

  assign stall_s    = !bus.pcwrite_i && !bus.branch_taken_i;
  assign flush_s    = bus.ifid_flush_i;
  assign pc_plus4_s = pc_r + 32'd4;

  // Next-state for PC, IF/ID, tracker FSM, counters and watchdog.
  always_comb begin
    pc_nxt_s        = pc_r;
    instr_nxt_s     = instr_r;
    pc4_nxt_s       = pc4_r;
    valid_nxt_s     = valid_r;
    state_nxt_s     = state_r;
    stall_cnt_nxt_s = stall_cnt_r;
    flush_cnt_nxt_s = flush_cnt_r;
    run_nxt_s       = run_r;
    err_nxt_s       = err_r;

    if (bus.branch_taken_i) begin
      pc_nxt_s = bus.branch_target_i;
    end else if (bus.pcwrite_i) begin
      pc_nxt_s = pc_plus4_s;
    end else begin
      pc_nxt_s = pc_r;
    end

    if (flush_s) begin
      instr_nxt_s = 32'h0000_0000;
      pc4_nxt_s   = 32'h0000_0000;
      valid_nxt_s = 1'b0;
    end else if (bus.ifid_write_i) begin
      instr_nxt_s = bus.instr_i;
      pc4_nxt_s   = pc_plus4_s;
      valid_nxt_s = 1'b1;
    end else begin
      valid_nxt_s = valid_r;
    end

    // All three states share one transition rule; flush dominates stall.
    case (state_r)
      ST_RUN, ST_STALL, ST_REDIRECT: begin
        if (flush_s) begin
          state_nxt_s = ST_REDIRECT;
        end else if (stall_s) begin
          state_nxt_s = ST_STALL;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_RUN;
    endcase

    if (stall_s) begin
      stall_cnt_nxt_s = sat_inc(stall_cnt_r);
      run_nxt_s       = (run_r == MAX_RUN) ? MAX_RUN : run_r + {{(RUN_W-1){1'b0}}, 1'b1};
    end else begin
      run_nxt_s = {RUN_W{1'b0}};
    end

    if (flush_s) begin
      flush_cnt_nxt_s = sat_inc(flush_cnt_r);
    end else begin
      flush_cnt_nxt_s = flush_cnt_r;
    end

    if (run_nxt_s == MAX_RUN) begin
      err_nxt_s = 1'b1;
    end else begin
      err_nxt_s = err_r;
    end
  end

  // State registers with synchronous reset overriding every input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_r        <= PC_RESET;
      instr_r     <= 32'h0000_0000;
      pc4_r       <= 32'h0000_0000;
      valid_r     <= 1'b0;
      state_r     <= ST_RUN;
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
      run_r       <= {RUN_W{1'b0}};
      err_r       <= 1'b0;
    end else begin
      pc_r        <= pc_nxt_s;
      instr_r     <= instr_nxt_s;
      pc4_r       <= pc4_nxt_s;
      valid_r     <= valid_nxt_s;
      state_r     <= state_nxt_s;
      stall_cnt_r <= stall_cnt_nxt_s;
      flush_cnt_r <= flush_cnt_nxt_s;
      run_r       <= run_nxt_s;
      err_r       <= err_nxt_s;
    end
  end

  assign bus.pc_o         = pc_r;
  assign bus.ifid_instr_o = instr_r;
  assign bus.ifid_pc4_o   = pc4_r;
  assign bus.ifid_valid_o = valid_r;
  assign state_o          = state_r;
  assign stall_cnt_o      = stall_cnt_r;
  assign flush_cnt_o      = flush_cnt_r;
  assign stall_err_o      = err_r;

endmodule
